// File: rtl/vram_arbiter.sv
// Two-requester arbiter for one single-port tile/pixel RAM: display reads always win, updater bursts are capped while video is active.
// Grants are combinational, mem_* registered on the grant edge, rdata/rvalid one edge later; VRAM_ARB_STATS_EN adds grant counters.
module vram_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 12,
  parameter int BURST_MAX  = 8,
  parameter int STARVE_LIM = 255
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          video_on_i,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_addr_i,
  output logic          disp_gnt_o,
  output logic          disp_rvalid_o,
  output logic [DW-1:0] disp_rdata_o,
  input  logic          upd_req_i,
  input  logic          upd_we_i,
  input  logic [AW-1:0] upd_addr_i,
  input  logic [DW-1:0] upd_wdata_i,
  output logic          upd_gnt_o,
  output logic          upd_rvalid_o,
  output logic [DW-1:0] upd_rdata_o,
  output logic          upd_starve_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_disp_cnt_o,
  output logic [15:0]   stat_upd_cnt_o
`endif
);

  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] BURST_LIM = BCW'(BURST_MAX);
  localparam logic [7:0]     STARVE_C  = 8'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    UPD  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [7:0]     wait_q, wait_d;
  logic           starve_q, starve_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic           mem_we_q, mem_we_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           disp_rvalid_q, disp_rvalid_d;
  logic           upd_rvalid_q, upd_rvalid_d;
  logic [DW-1:0]  disp_rdata_q, disp_rdata_d;
  logic [DW-1:0]  upd_rdata_q, upd_rdata_d;
  logic           disp_gnt, upd_gnt;

  always_comb begin
    disp_gnt      = disp_req_i;
    upd_gnt       = upd_req_i && !disp_req_i && (!video_on_i || (burst_q < BURST_LIM));
    state_d       = IDLE;
    burst_d       = burst_q;
    wait_d        = wait_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    disp_rvalid_d = 1'b0;
    upd_rvalid_d  = 1'b0;
    disp_rdata_d  = disp_rdata_q;
    upd_rdata_d   = upd_rdata_q;

    if (disp_gnt) begin
      state_d    = DISP;
      mem_addr_d = disp_addr_i;
    end else if (upd_gnt) begin
      state_d    = UPD;
      mem_addr_d = upd_addr_i;
      mem_we_d   = upd_we_i;
      if (upd_we_i) mem_wdata_d = upd_wdata_i;
    end

    if (disp_gnt || !video_on_i) burst_d = '0;
    else if (upd_gnt)            burst_d = burst_q + 1'b1;

    if (upd_gnt || !upd_req_i)   wait_d = 8'd0;
    else if (wait_q != 8'hFF)    wait_d = wait_q + 8'd1;

    // The starve flag drops on the edge that serves the request, not a cycle later.
    starve_d = (wait_q >= STARVE_C) && upd_req_i && !upd_gnt;

    // state_q doubles as the return-data tag for the access now on the memory bus.
    disp_rvalid_d = (state_q == DISP);
    upd_rvalid_d  = (state_q == UPD) && !mem_we_q;
    if (disp_rvalid_d) disp_rdata_d = mem_rdata_i;
    if (upd_rvalid_d)  upd_rdata_d  = mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      burst_q       <= '0;
      wait_q        <= 8'd0;
      starve_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      disp_rvalid_q <= 1'b0;
      upd_rvalid_q  <= 1'b0;
      disp_rdata_q  <= '0;
      upd_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      wait_q        <= wait_d;
      starve_q      <= starve_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      disp_rvalid_q <= disp_rvalid_d;
      upd_rvalid_q  <= upd_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      upd_rdata_q   <= upd_rdata_d;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stat_disp_q, stat_upd_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_disp_q <= 16'd0;
      stat_upd_q  <= 16'd0;
    end else begin
      if (disp_gnt) stat_disp_q <= stat_disp_q + 16'd1;
      if (upd_gnt)  stat_upd_q  <= stat_upd_q + 16'd1;
    end
  end

  assign stat_disp_cnt_o = stat_disp_q;
  assign stat_upd_cnt_o  = stat_upd_q;
`endif

  assign disp_gnt_o    = disp_gnt;
  assign upd_gnt_o     = upd_gnt;
  assign disp_rvalid_o = disp_rvalid_q;
  assign disp_rdata_o  = disp_rdata_q;
  assign upd_rvalid_o  = upd_rvalid_q;
  assign upd_rdata_o   = upd_rdata_q;
  assign upd_starve_o  = starve_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_we_o      = mem_we_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule
